spi_slave: RTL
==============

# spi_slave

SPI mode-0 responder: receives MSB-first bytes on `mosi` and returns MSB-first bytes on `miso`, framed by active-low `cs_n`. It is the far end of the master-side serial shifter: it oversamples the external `sclk`/`cs_n`/`mosi` pins in the system clock domain. It delivers each received byte as a one-cycle strobe and pulls transmit bytes from a valid/ack holding interface. Sits between the SPI pads and the register/command logic of the peripheral.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `sclk`, `cs_n`, `mosi`; legal values 2–3.

Ports:
- `clk` in 1: system clock; must be ≥ 8× the `sclk` frequency (e.g. 50 MHz for 5 MHz `sclk`).
- `rst` in 1: synchronous, active-high reset.
- `sclk` in 1: SPI clock from the master; asynchronous to `clk`.
- `cs_n` in 1: active-low chip select; asynchronous.
- `mosi` in 1: serial data from the master; asynchronous.
- `miso` out 1: serial data to the master, MSB first; 0 when not selected.
- `rx_data` out 8: last complete received byte; held until the next byte completes.
- `rx_valid` out 1: one-cycle strobe; `rx_data` is new this cycle.
- `rx_abort` out 1: one-cycle strobe; `cs_n` deasserted with 1–7 bits of a byte received.
- `tx_data` in 8: next byte to transmit.
- `tx_valid` in 1: `tx_data` is valid; held until `tx_ack`.
- `tx_ack` out 1: one-cycle strobe; `tx_data` captured into the shifter.
- `tx_underrun` out 1: one-cycle strobe; load point reached with `tx_valid`=0, 0x00 sent.
- `busy` out 1: high while in ACTIVE.

## Operation
- Input conditioning: each pin passes through `SYNC_STAGES` flops, then one history flop. `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise` are one-cycle strobes from the last sync stage vs history.
- Reset: all sync/history flops for `cs_n` reset to 0, for `sclk` and `mosi` to 0. A `cs_n` held low through reset therefore produces no `cs_fall`; no transaction starts until `cs_n` is seen high, then low.
- States: IDLE, ACTIVE.
- IDLE → ACTIVE on `cs_fall`:
  - clear `bit_cnt` (3 bits) and the `byte_done` flag;
  - load `tx_shift` from `tx_data` with `tx_ack`, or 0x00 with `tx_underrun`.
- In ACTIVE, on `sclk_rise`:
  - `rx_shift` ← {`rx_shift`[6:0], `mosi_s`}; `bit_cnt`++ (wraps 7→0).
  - When `bit_cnt`=7: `rx_data` ← {`rx_shift`[6:0], `mosi_s`}, `rx_valid`=1 the next cycle, set `byte_done`.
- In ACTIVE, on `sclk_fall`:
  - if `byte_done`: reload `tx_shift` (same tx_valid/ack/underrun rule), clear `byte_done`;
  - else `tx_shift` ← {`tx_shift`[6:0], 0}.
- `miso` = `tx_shift`[7] in ACTIVE, 0 in IDLE (registered).
- ACTIVE → IDLE on `cs_rise`. If `bit_cnt`≠0, pulse `rx_abort` and discard the partial byte; `rx_data` is unchanged. A loaded but unsent tx byte is dropped; it is not re-acked.
- `cs_rise` and `sclk_rise` in the same cycle: `cs_rise` wins and the edge is ignored.
- `rst` mid-transfer: immediate IDLE. Partial byte discarded, no `rx_abort` or `rx_valid`.

## Timing
- Reset values: `miso`=0, `rx_data`=0x00, `rx_valid`=0, `rx_abort`=0, `tx_ack`=0, `tx_underrun`=0, `busy`=0.
- Pin-to-strobe latency: `SYNC_STAGES`+1 `clk` cycles from a pin edge to its strobe.
- `rx_valid` rises one cycle after the `sclk_rise` strobe of the 8th bit, i.e. `SYNC_STAGES`+2 cycles after the physical edge.
- `miso` changes one cycle after `cs_fall` or `sclk_fall`. With `SYNC_STAGES`=2 this is ≤ 4 `clk` cycles after the pin edge, inside half an `sclk` period at ≥ 8× ratio.
- `tx_ack` is coincident with the cycle `tx_shift` loads. `tx_data` must be valid no later than the `cs_fall` / load-point strobe cycle.
- Back-to-back bytes without `cs_n` deassertion are supported indefinitely; `bit_cnt` wraps.

## Test plan
- Reset with `cs_n`=0 held, release, pulse `sclk` 8 times → no `rx_valid`, `busy`=0, `miso`=0.
- `cs_n` low, master sends 0xA5 with `tx_data`=0x3C, `tx_valid`=1 → `tx_ack` once after `cs_fall`, `miso` bits 0,0,1,1,1,1,0,0, `rx_data`=0xA5 with a single `rx_valid`.
- Two back-to-back bytes 0x01, 0xFE; second `tx_valid` deasserted → `rx_valid` twice with 0x01 then 0xFE, `tx_underrun` at the 8th `sclk` fall, second `miso` byte 0x00.
- `cs_n` deasserted after 5 bits of 0xFF → `rx_abort` pulse, `rx_data` retains previous 0xA5, `busy`=0; next frame of 0x5A received correctly.
- Assert `rst` after 3 bits, release with `cs_n` still low → no strobes, no activity until `cs_n` goes high then low.
- `cs_n` rise forced into the same `clk` cycle as the 8th `sclk_rise` → `rx_valid` not asserted, `rx_abort` pulses.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples sclk/cs_n/mosi in the clk domain, delivers
// received bytes as strobes and pulls transmit bytes through a valid/ack port.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_abort,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ack,
    output logic       tx_underrun,
    output logic       busy
);
    localparam int unsigned DW  = 8;
    localparam int unsigned BCW = 3;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                sclk_hist_q, cs_hist_q;
    logic [DW-1:0]       rx_shift_q, rx_shift_d;
    logic [DW-1:0]       tx_shift_q, tx_shift_d;
    logic [DW-1:0]       rx_data_q, rx_data_d;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                byte_done_q, byte_done_d;
    logic                miso_q, miso_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_abort_q, rx_abort_d;
    logic                tx_ack_q, tx_ack_d;
    logic                tx_underrun_q, tx_underrun_d;
    logic                load_tx;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    // Pin synchronizers plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign cs_fall   = ~cs_s & cs_hist_q;
    assign cs_rise   = cs_s & ~cs_hist_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and strobe next-state; cs_rise takes priority over sclk edges
    always_comb begin
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        rx_data_d     = rx_data_q;
        bit_cnt_d     = bit_cnt_q;
        byte_done_d   = byte_done_q;
        rx_valid_d    = 1'b0;
        rx_abort_d    = 1'b0;
        tx_ack_d      = 1'b0;
        tx_underrun_d = 1'b0;
        load_tx       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    bit_cnt_d   = '0;
                    byte_done_d = 1'b0;
                    load_tx     = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    rx_abort_d = (bit_cnt_q != '0);
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DW-2:0], mosi_s};
                    bit_cnt_d  = BCW'(bit_cnt_q + BCW'(1));
                    if (bit_cnt_q == BCW'(DW - 1)) begin
                        rx_data_d   = {rx_shift_q[DW-2:0], mosi_s};
                        rx_valid_d  = 1'b1;
                        byte_done_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (byte_done_q) begin
                        load_tx     = 1'b1;
                        byte_done_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DW-2:0], 1'b0};
                    end
                end
            end
            default: ;
        endcase
        if (load_tx) begin
            if (tx_valid) begin
                tx_shift_d = tx_data;
                tx_ack_d   = 1'b1;
            end else begin
                tx_shift_d    = '0;
                tx_underrun_d = 1'b1;
            end
        end
        miso_d = (state_d == ACTIVE) ? tx_shift_d[DW-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            rx_data_q     <= '0;
            bit_cnt_q     <= '0;
            byte_done_q   <= 1'b0;
            miso_q        <= 1'b0;
            rx_valid_q    <= 1'b0;
            rx_abort_q    <= 1'b0;
            tx_ack_q      <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            rx_data_q     <= rx_data_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_done_q   <= byte_done_d;
            miso_q        <= miso_d;
            rx_valid_q    <= rx_valid_d;
            rx_abort_q    <= rx_abort_d;
            tx_ack_q      <= tx_ack_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    assign miso        = miso_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_abort    = rx_abort_q;
    assign tx_ack      = tx_ack_q;
    assign tx_underrun = tx_underrun_q;
    assign busy        = (state_q == ACTIVE);

endmodule
